// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: sizing constants and fetch packet layout shared by the instruction buffer slice
package inst_buffer_pkg;
    localparam int IB_DEPTH = 16;
    localparam int FETCH_WIDTH = 4;
    localparam int DISPATCH_WIDTH = 3;
    localparam int IB_IDX_BITS = $clog2(IB_DEPTH);
    localparam int DC_BITS = $clog2(DISPATCH_WIDTH + 1);
    localparam int OFF_BITS = $clog2(FETCH_WIDTH);
    localparam int NIN_BITS = $clog2(FETCH_WIDTH + 1);
    typedef logic [IB_IDX_BITS-1:0] ib_idx_t;
    typedef logic [IB_IDX_BITS:0] ib_cnt_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        bp_pred_taken;
        logic [31:0] bp_pred_target;
        logic [7:0]  ghr_snapshot;
    } fetch_packet_t;
endpackage

// File: rtl/inst_buffer_if.sv
// inst_buffer_if: fetch-side write lanes and dispatch-side read lanes of the instruction buffer
interface inst_buffer_if;
    import inst_buffer_pkg::*;
    fetch_packet_t [FETCH_WIDTH-1:0]    fetch_packet;
    ib_cnt_t                            ib_free_slots;
    logic                               flush;
    fetch_packet_t [DISPATCH_WIDTH-1:0] ib_out;
    logic [DC_BITS-1:0]                 dispatch_count;
    logic                               overflow_err;
    modport master(output fetch_packet, flush, dispatch_count, input ib_free_slots, ib_out, overflow_err);
    modport slave(input fetch_packet, flush, dispatch_count, output ib_free_slots, ib_out, overflow_err);
endinterface

// File: rtl/inst_buffer_compact.sv
// inst_buffer_compact: prefix sum over lane valid bits giving each lane its packed write offset
module inst_buffer_compact
    import inst_buffer_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0]               valid,
    output logic [FETCH_WIDTH-1:0][OFF_BITS-1:0] offset,
    output logic [NIN_BITS-1:0]                  n_in
);
    always_comb begin
        n_in = '0;
        offset = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            offset[i] = n_in[OFF_BITS-1:0];
            n_in = n_in + NIN_BITS'(valid[i]);
        end
    end
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction FIFO compacting sparse fetch lanes and presenting the oldest entries to dispatch
module inst_buffer
    import inst_buffer_pkg::*;
(
    input logic        clock,
    input logic        reset,
    inst_buffer_if.slave ib
);
    fetch_packet_t mem [IB_DEPTH];
    ib_idx_t head, tail;
    ib_cnt_t count, n_acc, n_out, lim, req;
    logic [FETCH_WIDTH-1:0] vmask;
    logic [FETCH_WIDTH-1:0][OFF_BITS-1:0] offset;
    logic [NIN_BITS-1:0] n_in;
    logic accept, ovf;

    always_comb begin
        vmask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) vmask[i] = ib.fetch_packet[i].valid;
    end

    inst_buffer_compact u_compact (.valid(vmask), .offset(offset), .n_in(n_in));

    // space is judged on start-of-cycle occupancy; same-cycle pops are not credited
    assign accept = ib_cnt_t'(n_in) <= ib.ib_free_slots;
    assign n_acc = accept ? ib_cnt_t'(n_in) : '0;
    assign req = ib_cnt_t'(ib.dispatch_count);
    assign lim = count < ib_cnt_t'(DISPATCH_WIDTH) ? count : ib_cnt_t'(DISPATCH_WIDTH);
    assign n_out = req < lim ? req : lim;
    assign ib.ib_free_slots = ib_cnt_t'(IB_DEPTH) - count;
    assign ib.overflow_err = ovf;

    always_ff @(posedge clock) begin
        if (reset || ib.flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            head <= head + ib_idx_t'(n_out);
            tail <= tail + ib_idx_t'(n_acc);
            count <= count + n_acc - n_out;
        end
        ovf <= reset ? 1'b0 : (ovf | (!ib.flush && !accept));
    end

    always_ff @(posedge clock) begin
        if (!reset && !ib.flush && accept)
            for (int i = 0; i < FETCH_WIDTH; i++)
                if (vmask[i]) mem[tail + ib_idx_t'(offset[i])] <= ib.fetch_packet[i];
    end

    always_comb begin
        ib.ib_out = '0;
        for (int j = 0; j < DISPATCH_WIDTH; j++) begin
            ib.ib_out[j] = mem[head + ib_idx_t'(j)];
            ib.ib_out[j].valid = count > ib_cnt_t'(j);
        end
    end
endmodule
